instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Streaming RV32I instruction encoder. It is the inverse of the opcode type decoder: it takes a one-hot instruction class plus register, funct and immediate fields, and assembles the 32-bit instruction word. Each word is tagged with an incrementing instruction-memory byte address and held in a 2-entry output buffer with valid/ready handshakes on both sides. It sits between test/program generators and the instruction-memory write port of the single-cycle core.

Parameters:
ADDR_W, 32, width of the generated instruction-memory byte address
BASE_ADDR, 32'h0000_0000, address assigned to the first word after reset or clr

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
clr  input  1  synchronous flush: empties buffer, reloads address, clears err
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a bundle
type_sel  input  8  one-hot class {lui,jal,jalr,itype,branch,store,load,r} (bit7..bit0)
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
funct3  input  3  funct3 field
funct7  input  7  funct7 field (R-type only)
imm  input  32  immediate, unshifted byte value (U-type: imm[31:12] used)
out_valid  output  1  encoded word available
out_ready  input  1  consumer accepts word
instr  output  32  encoded instruction
addr  output  ADDR_W  byte address of instr
err  output  1  sticky: an illegal type_sel was accepted

Behaviour:
- Reset (rst=0, async): buffer empty, out_valid=0, instr=0, addr=BASE_ADDR, err=0, in_ready=1 after release.
- Accept when in_valid & in_ready at a rising edge. Output is registered: the word is visible with out_valid=1 from the next cycle, so latency is 1 cycle.
- Buffer: 2 entries, FIFO order. in_ready = (count<2), computed from registered count. When count==2, a pop raises in_ready in the next cycle. Simultaneous push and pop at count==1 keeps count=1.
- Pop when out_valid & out_ready. instr and addr hold stable while out_valid=1 and out_ready=0. When empty, instr and addr hold their last value.
- Opcodes: r 0110011, load 0000011, store 0100011, branch 1100011, itype 0010011, jalr 1100111, jal 1101111, lui 0110111.
- Field packing:
  - R: {funct7,rs2,rs1,funct3,rd,op}
  - I (load/itype/jalr): {imm[11:0],rs1,funct3,rd,op}; jalr forces funct3=000
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],op}
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,jal op}
  - U: {imm[31:12],rd,op}
  - Unused fields are ignored. imm[0] is silently dropped for B/J.
- Address counter: the word pushed gets the current counter value; the counter then advances by 4, modulo 2^ADDR_W (wraps to 0, not to BASE_ADDR).
- Illegal type_sel (zero or more than one bit set): the bundle is still accepted (handshake completes), no word is pushed, the address does not advance, and err is set. err stays set until clr or rst.
- clr: next edge empties buffer (out_valid=0), addr counter=BASE_ADDR, err=0. clr has priority over a same-cycle push or pop; that push is discarded, and in_ready is 0 while clr=1.
- Reset mid-stream: all buffered words are lost; there is no partial-output state.

Decomposition:
- Shared header rv32i_defs.vh: the 8 opcode constants, type_sel bit indices (matching decoder output order), and the jalr funct3 constant. The decoder and this encoder both use it.
- Sub-module instr_skid_buf: a 2-entry FIFO of {addr,instr} with count, handling the valid/ready handshakes.
- Packing is a combinational function in instr_encoder.

Test Plan:
- Reset, then r class with rd=3, rs1=1, rs2=2, funct3=0, funct7=0 -> instr=0x002081B3, addr=0. Then same with funct7=0x20 -> 0x402081B3, addr=4.
- itype with rd=5, rs1=0, imm=-1 -> 0xFFF00293. store with rs1=1, rs2=2, funct3=010, imm=4 -> 0x0020A223. lui with rd=1, imm=0x12345000 -> 0x123450B7. jal with rd=0, imm=8 -> 0x0080006F. Addresses must be consecutive multiples of 4.
- out_ready=0 while pushing 3 bundles -> in_ready falls after 2 accepts, and instr/addr stay stable. Raise out_ready -> words drain in order, and in_ready returns 1 cycle after the first pop.
- type_sel=8'b0000_0011, then 8'b0 -> err=1, no out_valid, address unchanged. The next legal bundle gets the unchanged address.
- clr asserted with 2 words buffered and in_valid high -> out_valid=0, err=0, next word gets addr=BASE_ADDR. With ADDR_W=4 and 5 pushes, addresses are 0,4,8,12,0 (wrap).
- rst pulsed low mid-drain, asynchronously -> out_valid drops immediately, and addr restarts at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding constants: major opcodes, type_sel bit positions
// (same order as the opcode type decoder's one-hot output) and the fixed
// funct3 for jalr. Imported by the encoder and its output buffer.
package instr_encoder_pkg;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_ITYPE  = 7'b0010011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_LUI    = 7'b0110111
  } opcode_e;

  // Bit index of each class inside type_sel.
  localparam int SEL_R      = 0;
  localparam int SEL_LOAD   = 1;
  localparam int SEL_STORE  = 2;
  localparam int SEL_BRANCH = 3;
  localparam int SEL_ITYPE  = 4;
  localparam int SEL_JALR   = 5;
  localparam int SEL_JAL    = 6;
  localparam int SEL_LUI    = 7;

  localparam logic [2:0] F3_JALR = 3'b000;

endpackage

// File: rtl/instr_encoder_skid_buf.sv
// Purpose : 2-entry FIFO of {addr,instr} words with valid/ready on both sides.
// Latency : 1 cycle push-to-output; head register drives the output directly.
// Backpr. : push refused when full (count==2); head and spare hold while pop_ready=0.
// Ports   : clk, rst (async active-low), clr (sync flush), push_valid/push_data,
//           pop_valid/pop_ready/pop_data, count (registered occupancy 0..2).
module instr_skid_buf
  import instr_encoder_pkg::*;
#(
  parameter int           W       = 64,
  parameter logic [W-1:0] RST_DAT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push_valid,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data,
  output logic [1:0]   count
);

  // head is the output register; spare holds the second-oldest word.
  // Keeping the output in a dedicated register means the last popped
  // word stays visible when the buffer runs empty.
  logic [W-1:0] head;
  logic [W-1:0] spare;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign pop_valid = (cnt != 2'd0);
  assign pop_data  = head;
  assign count     = cnt;
  assign do_push   = push_valid && (cnt != 2'd2);
  assign do_pop    = pop_valid && pop_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= 2'd0;
      head  <= RST_DAT;
      spare <= '0;
    end else if (clr) begin
      cnt <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) head <= push_data;
          else             spare <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          if (cnt == 2'd2) head <= spare;
          cnt <= cnt - 2'd1;
        end
        // Both at once only happens with exactly one word held:
        // the new word replaces the departing head, count unchanged.
        2'b11: head <= push_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Purpose : RV32I encoder; packs a one-hot class plus fields into a 32-bit
//           instruction tagged with an incrementing byte address.
// Latency : 1 cycle (word is visible the cycle after acceptance).
// Backpr. : in_ready drops when the 2-entry buffer is full or clr is high.
// Ports   : clk, rst (async active-low), clr; in_valid/in_ready with type_sel,
//           rd, rs1, rs2, funct3, funct7, imm; out_valid/out_ready with instr,
//           addr; err (sticky illegal type_sel).
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        type_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] addr,
  output logic              err
);

  localparam int W = ADDR_W + 32;

  function automatic logic [31:0] pack_instr(
    input logic [7:0]  sel,
    input logic [4:0]  f_rd,
    input logic [4:0]  f_rs1,
    input logic [4:0]  f_rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] im
  );
    logic [31:0] w;
    w = '0;
    if (sel[SEL_R])
      w = {f7, f_rs2, f_rs1, f3, f_rd, OP_R};
    else if (sel[SEL_LOAD])
      w = {im[11:0], f_rs1, f3, f_rd, OP_LOAD};
    else if (sel[SEL_ITYPE])
      w = {im[11:0], f_rs1, f3, f_rd, OP_ITYPE};
    else if (sel[SEL_JALR])
      w = {im[11:0], f_rs1, F3_JALR, f_rd, OP_JALR};
    else if (sel[SEL_STORE])
      w = {im[11:5], f_rs2, f_rs1, f3, im[4:0], OP_STORE};
    else if (sel[SEL_BRANCH])
      w = {im[12], im[10:5], f_rs2, f_rs1, f3, im[4:1], im[11], OP_BRANCH};
    else if (sel[SEL_JAL])
      w = {im[20], im[10:1], im[11], im[19:12], f_rd, OP_JAL};
    else if (sel[SEL_LUI])
      w = {im[31:12], f_rd, OP_LUI};
    return w;
  endfunction

  logic              legal;
  logic              accept;
  logic              push;
  logic [1:0]        count;
  logic [ADDR_W-1:0] addr_cnt;
  logic              err_q;
  logic [31:0]       word;
  logic [W-1:0]      pop_data;

  assign legal    = $onehot(type_sel);
  assign in_ready = (count != 2'd2) && !clr;
  assign accept   = in_valid && in_ready;
  // Illegal bundles complete the handshake but never reach the buffer.
  assign push     = accept && legal;
  assign word     = pack_instr(type_sel, rd, rs1, rs2, funct3, funct7, imm);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_cnt <= BASE_ADDR;
      err_q    <= 1'b0;
    end else if (clr) begin
      addr_cnt <= BASE_ADDR;
      err_q    <= 1'b0;
    end else begin
      // Natural modulo-2^ADDR_W wrap: rolls over to 0, not BASE_ADDR.
      if (push)             addr_cnt <= addr_cnt + ADDR_W'(4);
      if (accept && !legal) err_q    <= 1'b1;
    end
  end

  instr_skid_buf #(
    .W       (W),
    .RST_DAT ({BASE_ADDR, 32'h0})
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .push_valid (push),
    .push_data  ({addr_cnt, word}),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (pop_data),
    .count      (count)
  );

  assign addr  = pop_data[W-1:32];
  assign instr = pop_data[31:0];
  assign err   = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a 32-bit-address instance for encoding,
// handshake, error, flush and reset behaviour, plus a 4-bit-address instance
// sharing the same inputs to observe address wrap.
module tb_instr_encoder;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  type_sel;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [31:0] addr;
  logic        err;

  logic        in_ready4;
  logic        out_valid4;
  logic [31:0] instr4;
  logic [3:0]  addr4;
  logic        err4;

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] S_R      = 8'h01;
  localparam logic [7:0] S_LOAD   = 8'h02;
  localparam logic [7:0] S_STORE  = 8'h04;
  localparam logic [7:0] S_BRANCH = 8'h08;
  localparam logic [7:0] S_ITYPE  = 8'h10;
  localparam logic [7:0] S_JALR   = 8'h20;
  localparam logic [7:0] S_JAL    = 8'h40;
  localparam logic [7:0] S_LUI    = 8'h80;

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .type_sel(type_sel), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .addr(addr), .err(err)
  );

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'h0)) dut4 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready4),
    .type_sel(type_sel), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid4), .out_ready(out_ready),
    .instr(instr4), .addr(addr4), .err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_b(input logic [7:0] s, input logic [4:0] d, input logic [4:0] a,
                       input logic [4:0] b, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im);
    type_sel = s; rd = d; rs1 = a; rs2 = b; funct3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic send(input logic [7:0] s, input logic [4:0] d, input logic [4:0] a,
                      input logic [4:0] b, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] im);
    set_b(s, d, a, b, f3, f7, im);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_b(8'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // Streaming through every class with consumer always ready
    out_ready = 1'b1;
    send(S_R, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'h0);
    chk("r_valid", 32'(out_valid), 32'h1);
    chk("r_instr", instr, 32'h002081B3);
    chk("r_addr", addr, 32'h0);
    send(S_R, 5'd3, 5'd1, 5'd2, 3'b000, 7'h20, 32'h0);
    chk("sub_instr", instr, 32'h402081B3);
    chk("sub_addr", addr, 32'h4);
    send(S_ITYPE, 5'd5, 5'd0, 5'd0, 3'b000, 7'h00, 32'hFFFF_FFFF);
    chk("itype_instr", instr, 32'hFFF00293);
    chk("itype_addr", addr, 32'h8);
    send(S_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 7'h00, 32'h4);
    chk("store_instr", instr, 32'h0020A223);
    chk("store_addr", addr, 32'hC);
    send(S_LUI, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'h1234_5000);
    chk("lui_instr", instr, 32'h123450B7);
    chk("lui_addr", addr, 32'h10);
    send(S_JAL, 5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'h8);
    chk("jal_instr", instr, 32'h0080006F);
    chk("jal_addr", addr, 32'h14);
    send(S_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 7'h00, 32'hFFFF_FFFC);
    chk("branch_instr", instr, 32'hFE208EE3);
    chk("branch_addr", addr, 32'h18);
    send(S_LOAD, 5'd6, 5'd2, 5'd0, 3'b010, 7'h00, 32'h8);
    chk("load_instr", instr, 32'h00812303);
    chk("load_addr", addr, 32'h1C);
    send(S_JALR, 5'd1, 5'd5, 5'd0, 3'b111, 7'h00, 32'h0);
    chk("jalr_instr", instr, 32'h000280E7);
    chk("jalr_addr", addr, 32'h20);
    tick();
    chk("drain_valid", 32'(out_valid), 32'h0);
    chk("empty_hold_instr", instr, 32'h000280E7);
    chk("empty_hold_addr", addr, 32'h20);

    // Backpressure: fill both entries, third bundle stalls
    out_ready = 1'b0;
    set_b(S_R, 5'd7, 5'd1, 5'd2, 3'b000, 7'h00, 32'h0);
    in_valid = 1'b1;
    tick();
    chk("bp1_valid", 32'(out_valid), 32'h1);
    chk("bp1_instr", instr, 32'h002083B3);
    chk("bp1_addr", addr, 32'h24);
    chk("bp1_in_ready", 32'(in_ready), 32'h1);
    set_b(S_ITYPE, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'h1);
    tick();
    chk("bp2_in_ready", 32'(in_ready), 32'h0);
    chk("bp2_instr", instr, 32'h002083B3);
    chk("bp2_addr", addr, 32'h24);
    set_b(S_ITYPE, 5'd2, 5'd0, 5'd0, 3'b000, 7'h00, 32'h2);
    tick();
    chk("bp3_in_ready", 32'(in_ready), 32'h0);
    chk("bp3_instr", instr, 32'h002083B3);
    tick();
    chk("bp4_instr", instr, 32'h002083B3);
    chk("bp4_addr", addr, 32'h24);
    out_ready = 1'b1;
    tick();
    chk("pop1_instr", instr, 32'h00100093);
    chk("pop1_addr", addr, 32'h28);
    chk("pop1_in_ready", 32'(in_ready), 32'h1);
    tick();
    chk("pop2_instr", instr, 32'h00200113);
    chk("pop2_addr", addr, 32'h2C);
    in_valid = 1'b0;
    tick();
    chk("pop3_valid", 32'(out_valid), 32'h0);
    chk("pop3_in_ready", 32'(in_ready), 32'h1);

    // Illegal type_sel: two bits, then none
    set_b(8'b0000_0011, 5'd1, 5'd1, 5'd1, 3'b000, 7'h00, 32'h0);
    in_valid = 1'b1;
    tick();
    chk("ill2_err", 32'(err), 32'h1);
    chk("ill2_valid", 32'(out_valid), 32'h0);
    set_b(8'b0000_0000, 5'd1, 5'd1, 5'd1, 3'b000, 7'h00, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("ill0_err", 32'(err), 32'h1);
    chk("ill0_valid", 32'(out_valid), 32'h0);
    chk("ill0_addr", addr, 32'h2C);
    send(S_ITYPE, 5'd3, 5'd0, 5'd0, 3'b000, 7'h00, 32'h3);
    chk("post_ill_instr", instr, 32'h00300193);
    chk("post_ill_addr", addr, 32'h30);
    chk("post_ill_err", 32'(err), 32'h1);

    // clr with two words buffered and a bundle offered
    out_ready = 1'b0;
    send(S_R, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'h0);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    chk("full_head", instr, 32'h00300193);
    set_b(S_LUI, 5'd4, 5'd0, 5'd0, 3'b000, 7'h00, 32'hABCD_E000);
    in_valid = 1'b1;
    clr = 1'b1;
    tick();
    chk("clr_valid", 32'(out_valid), 32'h0);
    chk("clr_err", 32'(err), 32'h0);
    chk("clr_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("clr_push_dropped", 32'(out_valid), 32'h0);
    clr = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("clr_rel_in_ready", 32'(in_ready), 32'h1);
    send(S_R, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'h0);
    chk("post_clr_valid", 32'(out_valid), 32'h1);
    chk("post_clr_addr", addr, 32'h0);
    chk("post_clr_instr", instr, 32'h002081B3);

    // Address wrap on the 4-bit instance
    clr = 1'b1;
    tick();
    clr = 1'b0;
    out_ready = 1'b1;
    chk("w4_err", 32'(err4), 32'h0);
    for (int i = 0; i < 5; i++) begin
      send(S_ITYPE, 5'(i), 5'd0, 5'd0, 3'b000, 7'h00, 32'(i));
      chk("wrap_addr4", 32'(addr4), 32'((i * 4) % 16));
      chk("wrap_instr4", instr4, (32'(i) << 20) | (32'(i) << 7) | 32'h13);
      chk("wrap_addr32", addr, 32'(i * 4));
    end
    chk("w4_valid", 32'(out_valid4), 32'h1);
    chk("w4_in_ready", 32'(in_ready4), 32'h1);

    // Asynchronous reset mid-drain
    out_ready = 1'b0;
    send(S_R, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'h0);
    chk("pre_arst_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_addr", addr, 32'h0);
    #2;
    rst = 1'b1;
    tick();
    send(S_JAL, 5'd0, 5'd0, 5'd0, 3'b000, 7'h00, 32'h8);
    chk("post_arst_addr", addr, 32'h0);
    chk("post_arst_instr", instr, 32'h0080006F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
